// File: rtl/lc4_commit_monitor_pkg.sv
// Shared definitions for the LC4 commit monitor: stall classes, counter
// indices and the packed trace-record layout used by downstream checkers.
package lc4_commit_monitor_pkg;

    // Stall classification carried on test_stall
    typedef enum logic [1:0] {
        STALL_EXEC   = 2'd0,
        STALL_CACHE  = 2'd1,
        STALL_BRANCH = 2'd2,
        STALL_LOAD   = 2'd3
    } stall_e;

    // Performance counter slots
    localparam int CNT_CYCLES = 0;
    localparam int CNT_EXEC   = 1;
    localparam int CNT_CACHE  = 2;
    localparam int CNT_BRANCH = 3;
    localparam int CNT_LOAD   = 4;
    localparam int NUM_CNT    = 5;

    // Record: pc[16] insn[16] rf_we rf_wsel[3] rf_data[W] nzp_we nzp[3] dm_we dm_addr[3] dm_data[W]
    localparam int REC_FIXED_W = 44;

    function automatic int rec_w(input int word_size);
        return REC_FIXED_W + 2 * word_size;
    endfunction

    // LSB offsets of the record fields, for trace checkers slicing records
    function automatic int off_dm_data(input int word_size);
        return 0 * word_size;
    endfunction

    function automatic int off_nzp(input int word_size);
        return word_size + 4;
    endfunction

    function automatic int off_rf_data(input int word_size);
        return word_size + 8;
    endfunction

    function automatic int off_insn(input int word_size);
        return 2 * word_size + 12;
    endfunction

    function automatic int off_pc(input int word_size);
        return 2 * word_size + 28;
    endfunction

endpackage

// File: rtl/lc4_sync_fifo.sv
// Synchronous FIFO with a registered head word. Pointers carry an extra wrap
// bit so full and empty come from a plain compare. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is dropped.
module lc4_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             drop_o
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             empty, full, do_pop, do_push;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;

    assign valid_o = !empty;
    assign data_o  = head_q;

    // Next pointers and the word that will sit at the head after this edge
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (wr_ptr_d != rd_ptr_d) begin
            // The new head is the word being written when it lands in the head slot
            if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
                head_d = push_data_i;
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    // Pointer and head registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/lc4_commit_monitor.sv
// LC4 commit monitor: classifies every gwe-qualified cycle by stall reason,
// keeps saturating performance counters, and queues committed instructions
// as packed records behind a valid/ready port.
module lc4_commit_monitor
    import lc4_commit_monitor_pkg::*;
#(
    parameter int WORD_SIZE = 64,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 32,
    localparam int REC_W    = REC_FIXED_W + 2 * WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gwe,
    input  logic                 clr_stats,
    input  logic [1:0]           test_stall,
    input  logic [15:0]          test_cur_pc,
    input  logic [15:0]          test_cur_insn,
    input  logic                 test_regfile_we,
    input  logic [2:0]           test_regfile_wsel,
    input  logic [WORD_SIZE-1:0] test_regfile_data,
    input  logic                 test_nzp_we,
    input  logic [2:0]           test_nzp_new_bits,
    input  logic                 test_dmem_we,
    input  logic [2:0]           test_dmem_addr,
    input  logic [WORD_SIZE-1:0] test_dmem_data,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [REC_W-1:0]     rec_data,
    output logic [CNT_W-1:0]     cnt_cycles,
    output logic [CNT_W-1:0]     cnt_exec,
    output logic [CNT_W-1:0]     cnt_cache,
    output logic [CNT_W-1:0]     cnt_branch,
    output logic [CNT_W-1:0]     cnt_load,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] cnt_q [NUM_CNT];
    logic [CNT_W-1:0] cnt_d [NUM_CNT];
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             ovf_q, ovf_d;
    logic             push, fifo_drop;
    logic [REC_W-1:0] rec_word;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Only non-stalled sample cycles commit an instruction
    assign push = gwe && (test_stall == STALL_EXEC);

    assign rec_word = {test_cur_pc, test_cur_insn,
                       test_regfile_we, test_regfile_wsel, test_regfile_data,
                       test_nzp_we, test_nzp_new_bits,
                       test_dmem_we, test_dmem_addr, test_dmem_data};

    lc4_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (push),
        .push_data_i (rec_word),
        .pop_i       (rec_ready),
        .valid_o     (rec_valid),
        .data_o      (rec_data),
        .drop_o      (fifo_drop)
    );

    // Counter, drop and overflow update for a sample cycle; clear wins
    always_comb begin
        cnt_d  = cnt_q;
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (gwe) begin
            if (clr_stats) begin
                for (int i = 0; i < NUM_CNT; i++) cnt_d[i] = '0;
                drop_d = '0;
                ovf_d  = 1'b0;
            end else begin
                cnt_d[CNT_CYCLES] = sat_inc(cnt_q[CNT_CYCLES]);
                // An unknown stall code counts as a cycle but matches no class
                case (test_stall)
                    STALL_EXEC:   cnt_d[CNT_EXEC]   = sat_inc(cnt_q[CNT_EXEC]);
                    STALL_CACHE:  cnt_d[CNT_CACHE]  = sat_inc(cnt_q[CNT_CACHE]);
                    STALL_BRANCH: cnt_d[CNT_BRANCH] = sat_inc(cnt_q[CNT_BRANCH]);
                    STALL_LOAD:   cnt_d[CNT_LOAD]   = sat_inc(cnt_q[CNT_LOAD]);
                    default: ;
                endcase
                if (fifo_drop) begin
                    drop_d = sat_inc(drop_q);
                    ovf_d  = 1'b1;
                end
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cnt_cycles = cnt_q[CNT_CYCLES];
    assign cnt_exec   = cnt_q[CNT_EXEC];
    assign cnt_cache  = cnt_q[CNT_CACHE];
    assign cnt_branch = cnt_q[CNT_BRANCH];
    assign cnt_load   = cnt_q[CNT_LOAD];
    assign drop_cnt   = drop_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_lc4_commit_monitor.sv
// Self-checking bench for lc4_commit_monitor. A queue-based model tracks the
// record stream and counters; a second instance with 4-bit counters exercises
// saturation against the same stimulus.
module tb_lc4_commit_monitor;

    localparam int W     = 64;
    localparam int DEPTH = 16;
    localparam int REC_W = 44 + 2 * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, gwe, clr_stats, rec_ready;
    logic [1:0]   stall;
    logic [15:0]  pc, insn;
    logic         rf_we, nzp_we, dm_we;
    logic [2:0]   rf_wsel, nzp_bits, dm_addr;
    logic [W-1:0] rf_data, dm_data;

    logic             rec_valid, ovf;
    logic [REC_W-1:0] rec_data;
    logic [31:0]      c_cyc, c_exec, c_cache, c_branch, c_load, c_drop;
    logic             rec_valid2, ovf2;
    logic [REC_W-1:0] rec_data2;
    logic [3:0]       d_cyc, d_exec, d_cache, d_branch, d_load, d_drop;

    lc4_commit_monitor #(.WORD_SIZE(W), .DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .gwe(gwe), .clr_stats(clr_stats), .test_stall(stall),
        .test_cur_pc(pc), .test_cur_insn(insn),
        .test_regfile_we(rf_we), .test_regfile_wsel(rf_wsel), .test_regfile_data(rf_data),
        .test_nzp_we(nzp_we), .test_nzp_new_bits(nzp_bits),
        .test_dmem_we(dm_we), .test_dmem_addr(dm_addr), .test_dmem_data(dm_data),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .cnt_cycles(c_cyc), .cnt_exec(c_exec), .cnt_cache(c_cache), .cnt_branch(c_branch),
        .cnt_load(c_load), .drop_cnt(c_drop), .overflow(ovf)
    );

    lc4_commit_monitor #(.WORD_SIZE(W), .DEPTH(DEPTH), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .gwe(gwe), .clr_stats(clr_stats), .test_stall(stall),
        .test_cur_pc(pc), .test_cur_insn(insn),
        .test_regfile_we(rf_we), .test_regfile_wsel(rf_wsel), .test_regfile_data(rf_data),
        .test_nzp_we(nzp_we), .test_nzp_new_bits(nzp_bits),
        .test_dmem_we(dm_we), .test_dmem_addr(dm_addr), .test_dmem_data(dm_data),
        .rec_valid(rec_valid2), .rec_ready(rec_ready), .rec_data(rec_data2),
        .cnt_cycles(d_cyc), .cnt_exec(d_exec), .cnt_cache(d_cache), .cnt_branch(d_branch),
        .cnt_load(d_load), .drop_cnt(d_drop), .overflow(ovf2)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_cnt[inst][k]: k = 0 cycles, 1..4 stall classes, 5 drops
    logic [REC_W-1:0] q[$];
    longint unsigned  m_cnt [2][6];
    longint unsigned  m_max [2];
    bit               m_ovf;

    function automatic longint unsigned sat(input longint unsigned v, input longint unsigned mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    function automatic logic [REC_W-1:0] pack_rec();
        return {pc, insn, rf_we, rf_wsel, rf_data, nzp_we, nzp_bits, dm_we, dm_addr, dm_data};
    endfunction

    task automatic model_reset();
        q.delete();
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < 6; k++) m_cnt[m][k] = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step();
        bit dropped;
        dropped = 1'b0;
        if (q.size() > 0 && rec_ready) q.delete(0);
        if (gwe && stall == 2'd0) begin
            if (q.size() < DEPTH) q.push_back(pack_rec());
            else dropped = 1'b1;
        end
        if (gwe) begin
            if (clr_stats) begin
                for (int m = 0; m < 2; m++)
                    for (int k = 0; k < 6; k++) m_cnt[m][k] = 0;
                m_ovf = 1'b0;
            end else begin
                for (int m = 0; m < 2; m++) begin
                    m_cnt[m][0] = sat(m_cnt[m][0], m_max[m]);
                    m_cnt[m][1 + int'(stall)] = sat(m_cnt[m][1 + int'(stall)], m_max[m]);
                    if (dropped) m_cnt[m][5] = sat(m_cnt[m][5], m_max[m]);
                end
                if (dropped) m_ovf = 1'b1;
            end
        end
    endtask

    // One clock: model follows the edge, then return at the falling edge
    task automatic cyc();
        @(posedge clk);
        if (rst) model_step();
        else model_reset();
        @(negedge clk);
    endtask

    // Continuous comparison of both instances against the model
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("rec_valid", rec_valid, q.size() > 0);
            check("rec_valid2", rec_valid2, q.size() > 0);
            if (q.size() > 0) begin
                check("rec_data", rec_data, q[0]);
                check("rec_data2", rec_data2, q[0]);
            end
            check("cnt_cycles", c_cyc, m_cnt[0][0]);
            check("cnt_exec", c_exec, m_cnt[0][1]);
            check("cnt_cache", c_cache, m_cnt[0][2]);
            check("cnt_branch", c_branch, m_cnt[0][3]);
            check("cnt_load", c_load, m_cnt[0][4]);
            check("drop_cnt", c_drop, m_cnt[0][5]);
            check("overflow", ovf, m_ovf);
            check("cnt_cycles4", d_cyc, m_cnt[1][0]);
            check("cnt_exec4", d_exec, m_cnt[1][1]);
            check("cnt_cache4", d_cache, m_cnt[1][2]);
            check("cnt_branch4", d_branch, m_cnt[1][3]);
            check("cnt_load4", d_load, m_cnt[1][4]);
            check("drop_cnt4", d_drop, m_cnt[1][5]);
            check("overflow4", ovf2, m_ovf);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic zero_fields();
        pc = '0; insn = '0; rf_we = 0; rf_wsel = '0; rf_data = '0;
        nzp_we = 0; nzp_bits = '0; dm_we = 0; dm_addr = '0; dm_data = '0;
    endtask

    task automatic random_fields();
        pc = 16'($urandom); insn = 16'($urandom);
        rf_we = 1'($urandom); rf_wsel = 3'($urandom); rf_data = {$urandom, $urandom};
        nzp_we = 1'($urandom); nzp_bits = 3'($urandom);
        dm_we = 1'($urandom); dm_addr = 3'($urandom); dm_data = {$urandom, $urandom};
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, rec_valid, 1'b0);
        check({tag, "_data"}, rec_data, '0);
        check({tag, "_cycles"}, c_cyc, '0);
        check({tag, "_exec"}, c_exec, '0);
        check({tag, "_drop"}, c_drop, '0);
        check({tag, "_ovf"}, ovf, 1'b0);
        check({tag, "_cycles4"}, d_cyc, '0);
    endtask

    task automatic mid_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        #1 rst = 1'b1;
    endtask

    // Drain with rec_ready=1 until empty; returns record count and first pc
    task automatic drain(output int n, output logic [15:0] first_pc, output logic [15:0] last_pc);
        logic [REC_W-1:0] r;
        n = 0; first_pc = '0; last_pc = '0;
        gwe = 0; rec_ready = 1;
        for (int k = 0; k < 40; k++) begin
            if (!rec_valid) break;
            r = rec_data;
            if (n == 0) first_pc = r[REC_W-1 -: 16];
            last_pc = r[REC_W-1 -: 16];
            n++;
            cyc();
        end
        rec_ready = 0;
    endtask

    initial begin
        int n;
        int mode;
        logic [15:0] fpc, lpc;
        logic [REC_W-1:0] r;

        m_max[0] = 64'hFFFF_FFFF;
        m_max[1] = 64'd15;
        model_reset();
        rst = 0; gwe = 0; clr_stats = 0; rec_ready = 0; stall = 2'd0;
        zero_fields();

        // Reset held for three cycles, then released with gwe low
        repeat (3) cyc();
        check_all_zero("reset");
        rst = 1;
        pc = 16'h4444;
        repeat (3) cyc();
        check("idle_valid", rec_valid, 1'b0);

        // Stall pattern 0,1,2,3,0
        gwe = 1;
        for (int i = 0; i < 5; i++) begin
            stall = (i == 4) ? 2'd0 : 2'(i);
            pc = 16'h0010 + 16'(i);
            cyc();
        end
        gwe = 0; stall = 2'd0;
        check("t2_cycles", c_cyc, 32'd5);
        check("t2_exec", c_exec, 32'd2);
        check("t2_cache", c_cache, 32'd1);
        check("t2_branch", c_branch, 32'd1);
        check("t2_load", c_load, 32'd1);
        check("t2_model_cycles", m_cnt[0][0], 64'd5);
        check("t2_model_depth", q.size(), 2);
        drain(n, fpc, lpc);
        check("t2_drain_n", n, 2);
        check("t2_drain_pc", fpc, 16'h0010);

        // Single record with known fields, then consumed
        zero_fields();
        pc = 16'h8200; insn = 16'h1234; rf_we = 1; rf_wsel = 3'd5; rf_data = 64'hDEAD_BEEF;
        gwe = 1; stall = 2'd0;
        cyc();
        gwe = 0;
        check("t3_valid", rec_valid, 1'b1);
        check("t3_record", rec_data,
              {16'h8200, 16'h1234, 1'b1, 3'd5, 64'hDEAD_BEEF, 1'b0, 3'd0, 1'b0, 3'd0, 64'd0});
        rec_ready = 1;
        cyc();
        rec_ready = 0;
        check("t3_consumed", rec_valid, 1'b0);

        // 18 commits into a 16-deep FIFO with no consumer
        zero_fields();
        gwe = 1;
        for (int i = 0; i < 18; i++) begin
            pc = 16'h0100 + 16'(i);
            cyc();
        end
        gwe = 0;
        check("t4_drop", c_drop, 32'd2);
        check("t4_ovf", ovf, 1'b1);
        check("t4_model_depth", q.size(), 16);
        rec_ready = 1;
        for (int i = 0; i < 16; i++) begin
            r = rec_data;
            check("t4_order_valid", rec_valid, 1'b1);
            check("t4_order_pc", r[REC_W-1 -: 16], 16'h0100 + 16'(i));
            cyc();
        end
        rec_ready = 0;
        check("t4_empty", rec_valid, 1'b0);

        // Full FIFO with simultaneous push and pop
        gwe = 1;
        for (int i = 0; i < 16; i++) begin
            pc = 16'h0200 + 16'(i);
            cyc();
        end
        rec_ready = 1; pc = 16'h02FF;
        cyc();
        gwe = 0; rec_ready = 0;
        check("t5_drop", c_drop, 32'd2);
        check("t5_model_depth", q.size(), 16);
        drain(n, fpc, lpc);
        check("t5_drain_n", n, 16);
        check("t5_first_pc", fpc, 16'h0201);
        check("t5_last_pc", lpc, 16'h02FF);

        // Saturation in the 4-bit instance, then clear with a push in the same cycle
        check("t6_sat_cycles4", d_cyc, 4'd15);
        check("t6_sat_exec4", d_exec, 4'd15);
        check("t6_drop4", d_drop, 4'd2);
        gwe = 1;
        for (int i = 0; i < 3; i++) begin
            pc = 16'h0300 + 16'(i);
            cyc();
        end
        clr_stats = 1; pc = 16'h0303;
        cyc();
        clr_stats = 0; gwe = 0;
        check("t6_clr_cycles", c_cyc, 32'd0);
        check("t6_clr_exec", c_exec, 32'd0);
        check("t6_clr_drop", c_drop, 32'd0);
        check("t6_clr_ovf", ovf, 1'b0);
        check("t6_clr_cycles4", d_cyc, 4'd0);
        check("t6_fifo_kept", rec_valid, 1'b1);
        drain(n, fpc, lpc);
        check("t6_drain_n", n, 4);
        check("t6_first_pc", fpc, 16'h0300);
        check("t6_last_pc", lpc, 16'h0303);

        // Randomized traffic with varying consumer pressure and one mid-run reset
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) mid_reset();
            if (i % 250 == 0) mode = int'($urandom_range(0, 2));
            gwe       = ($urandom_range(0, 3) != 0);
            stall     = 2'($urandom_range(0, 3));
            clr_stats = ($urandom_range(0, 63) == 0);
            case (mode)
                0:       rec_ready = ($urandom_range(0, 7) == 0);
                1:       rec_ready = 1'($urandom_range(0, 1));
                default: rec_ready = ($urandom_range(0, 7) != 0);
            endcase
            random_fields();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
